// File: rtl/pe_row16_pkg.sv
// Shared definitions for the 16-PE multiply-accumulate row: operand width,
// row length and the derived result/counter widths.
package pe_row16_pkg;
    localparam int conv16_width = 8;
    localparam int PE_NUM       = 16;
    localparam int PSUM_W       = 2 * conv16_width;
    localparam int CNT_W        = $clog2(PE_NUM);

    typedef logic [conv16_width-1:0] operand_t;
    typedef logic [PSUM_W-1:0]       psum_t;
endpackage

// File: rtl/pe_row16_pe_unit.sv
// One processing element: holds an activation/weight pair, forwards it to the
// next PE in the shift chain and presents the full-width unsigned product.
module pe_unit
    import pe_row16_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     en,
    input  operand_t x_in,
    input  operand_t w_in,
    output operand_t x_out,
    output operand_t w_out,
    output psum_t    prod
);

    operand_t x_reg;
    operand_t w_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_reg <= '0;
            w_reg <= '0;
        end else if (en) begin
            x_reg <= x_in;
            w_reg <= w_in;
        end
    end

    assign x_out = x_reg;
    assign w_out = w_reg;
    assign prod  = psum_t'(x_reg) * psum_t'(w_reg);

endmodule

// File: rtl/pe_row16.sv
// Row of 16 PEs fed as a shift chain; every 16 enabled captures the products
// are summed (modulo the result width) and published with a one-cycle pulse.
module pe_row16
    import pe_row16_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     en,
    input  operand_t i_r,
    input  operand_t i_f,
    output psum_t    o_psum,
    output logic     end_pe
);

    operand_t           x_q  [PE_NUM];
    operand_t           w_q  [PE_NUM];
    psum_t              prod [PE_NUM];
    psum_t              lvl  [PE_NUM];
    psum_t              tree_sum;
    logic [CNT_W-1:0]   cnt_reg;
    logic               pending_reg;
    psum_t              psum_reg;
    logic               end_pe_reg;

    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_pe
        if (gi == 0) begin : g_head
            pe_unit u_pe (
                .clk   (clk),
                .rstn  (rstn),
                .en    (en),
                .x_in  (i_r),
                .w_in  (i_f),
                .x_out (x_q[gi]),
                .w_out (w_q[gi]),
                .prod  (prod[gi])
            );
        end else begin : g_body
            pe_unit u_pe (
                .clk   (clk),
                .rstn  (rstn),
                .en    (en),
                .x_in  (x_q[gi-1]),
                .w_in  (w_q[gi-1]),
                .x_out (x_q[gi]),
                .w_out (w_q[gi]),
                .prod  (prod[gi])
            );
        end
    end

    // Pairwise reduction; carries out of the result width are dropped.
    always_comb begin
        for (int i = 0; i < PE_NUM; i++) begin
            lvl[i] = prod[i];
        end
        for (int s = PE_NUM / 2; s >= 1; s = s / 2) begin
            for (int i = 0; i < s; i++) begin
                lvl[i] = lvl[2*i] + lvl[2*i+1];
            end
        end
        tree_sum = lvl[0];
    end

    // pending_reg marks that the last edge captured the 16th sample, so the
    // chain now holds a full window; the sum is taken from pre-edge contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            psum_reg    <= '0;
            end_pe_reg  <= 1'b0;
        end else begin
            if (en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            pending_reg <= en && (cnt_reg == CNT_W'(PE_NUM - 1));
            end_pe_reg  <= pending_reg;
            if (pending_reg) begin
                psum_reg <= tree_sum;
            end
        end
    end

    assign o_psum = psum_reg;
    assign end_pe = end_pe_reg;

endmodule

// File: tb/tb_pe_row16.sv
// Scoreboard bench for pe_row16: a window-level model predicts each result and
// the cycle of its pulse; a monitor checks every cycle against those predictions.
module tb_pe_row16;
    import pe_row16_pkg::*;

    logic     clk = 1'b0;
    logic     rstn;
    logic     en;
    operand_t i_r;
    operand_t i_f;
    psum_t    o_psum;
    logic     end_pe;

    typedef struct {
        int unsigned psum;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int unsigned last_psum = 0;
    int          win_n = 0;
    int unsigned win_acc = 0;

    pe_row16 dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .i_r    (i_r),
        .i_f    (i_f),
        .o_psum (o_psum),
        .end_pe (end_pe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 time unit after a rising edge and are captured on the next one.
    // A window result is due on the edge after its 16th capture.
    task automatic drive(input bit e, input int r, input int f);
        @(posedge clk);
        #1;
        en  = e;
        i_r = operand_t'(r);
        i_f = operand_t'(f);
        if (e && rstn) begin
            win_acc = win_acc + (int'(i_r) * int'(i_f));
            win_n++;
            if (win_n == PE_NUM) begin
                exp_q.push_back('{psum: win_acc % 65536, cyc: cyc + 2});
                win_n   = 0;
                win_acc = 0;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        en      = 1'b0;
        win_n   = 0;
        win_acc = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            tests++;
            if (o_psum !== '0 || end_pe !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_outputs: o_psum=%0d end_pe=%b, required 0/0", o_psum, end_pe);
            end
            last_psum = 0;
        end else if (end_pe === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL spurious_pulse: end_pe=1 at cycle %0d with o_psum=%0d, required no pulse", cyc, o_psum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(o_psum) != int'(e.psum) || cyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL window_sum: o_psum=%0d at cycle %0d, required %0d at cycle %0d",
                             o_psum, cyc, e.psum, e.cyc);
                end else begin
                    $display("[TB] window o_psum=%0d at cycle %0d ok", o_psum, cyc);
                end
                last_psum = e.psum;
            end
        end else begin
            tests++;
            if (end_pe !== 1'b0 || int'(o_psum) != int'(last_psum)) begin
                fails++;
                $display("[TB] FAIL hold: o_psum=%0d end_pe=%b at cycle %0d, required %0d/0",
                         o_psum, end_pe, cyc, last_psum);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        i_r  = '0;
        i_f  = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Ramp activations against a three-tap filter: 1*1 + 2*2 + 3*3 = 14.
        for (int k = 1; k <= 16; k++) drive(1'b1, k, (k <= 3) ? k : 0);
        idle(3);

        // All ones, then an all-zero window back to back.
        for (int k = 0; k < 16; k++) drive(1'b1, 1, 1);
        for (int k = 0; k < 16; k++) drive(1'b1, 0, 0);
        idle(3);

        // Maximum operands wrap the result modulo 2^16.
        for (int k = 0; k < 16; k++) drive(1'b1, 255, 255);
        idle(3);

        // Ramp window again with a 5-cycle enable gap after sample 8.
        for (int k = 1; k <= 8; k++) drive(1'b1, k, (k <= 3) ? k : 0);
        idle(5);
        for (int k = 9; k <= 16; k++) drive(1'b1, k, 0);
        idle(3);

        // Partial window discarded by reset; fresh window of twos gives 64.
        for (int k = 0; k < 10; k++) drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
        do_reset(3);
        for (int k = 0; k < 16; k++) drive(1'b1, 2, 2);
        idle(3);

        // Three continuous random windows.
        for (int k = 0; k < 48; k++) drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
        idle(2);

        // Random stream with random enable.
        for (int k = 0; k < 200; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        idle(5);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL missing_pulse: %0d windows still outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_row16.md
PE_ROW16 -- requirements
Module: pe_row16

Interface
REQ-001 Parameter conv16_width, default 8, operand width; SHALL come from shared package definition, not a module parameter.
REQ-002 Constant PE_NUM, default 16, number of PEs in the row; SHALL come from package definition.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  sample enable; when high, i_r/i_f are captured on the rising edge.
REQ-006 i_r  input  conv16_width  unsigned input-activation (row) sample.
REQ-007 i_f  input  conv16_width  unsigned filter-weight sample.
REQ-008 o_psum  output  2*conv16_width  registered partial sum of the last completed window.
REQ-009 end_pe  output  1  registered one-cycle pulse marking a new o_psum value.

Function
REQ-010 Row SHALL contain 16 PEs in a shift chain; each PE holds one activation register x and one weight register w.
REQ-011 On each rising edge with en=1: PE0 SHALL load i_r/i_f, and PEk SHALL load the x/w of PE(k-1), k=1..15.
REQ-012 With en=0 the chain and the sample counter SHALL hold their values.
REQ-013 A 4-bit sample counter SHALL increment on each enabled capture, wrapping 15->0; the capture that wraps it is the 16th sample of a window.
REQ-014 Windows SHALL be non-overlapping: samples 1-16 form window 0, samples 17-32 form window 1, and so on.
REQ-015 Each PE SHALL form the unsigned product x*w (2*conv16_width bits) combinationally.
REQ-016 An adder tree SHALL sum the 16 products; the result SHALL be truncated (modulo 2^(2*conv16_width)) to the o_psum width, with no saturation and no overflow flag.
REQ-017 On the rising edge after the 16th capture, o_psum SHALL load the tree sum and end_pe SHALL be 1; this happens regardless of en on that edge.
REQ-018 Latency: end_pe SHALL be high exactly one cycle, one clock after the 16th sample is captured.
REQ-019 end_pe SHALL be 0 in all other cycles.
REQ-020 o_psum SHALL hold its value between completions.
REQ-021 Simultaneous events: if en=1 on the completion edge, the sum uses pre-edge chain contents while the first sample of the next window shifts in; back-to-back windows SHALL lose no samples.
REQ-022 The result for a window SHALL equal the sum over t=1..16 of i_r(t)*i_f(t), in capture order.

Reset
REQ-023 rstn=0 SHALL asynchronously clear all PE x/w registers, the sample counter, the pending-completion flag, o_psum (0) and end_pe (0).
REQ-024 Reset mid-window SHALL discard the partial window; the next 16 enabled captures after release SHALL form a fresh window.
REQ-025 No output SHALL change while rstn=0.

Structure
REQ-026 Package definition SHALL hold conv16_width (8) and PE_NUM (16).
REQ-027 A single sub-module pe_unit SHALL be used, instantiated 16 times by generate; it holds x/w registers, forwards them, and outputs its product.
REQ-028 pe_row16 SHALL own the counter, the completion flag, the adder tree and the output registers.

Verification
REQ-029 After reset, en=1 with i_r=1..16 and i_f=1,2,3,0,...,0 -> o_psum=14 and end_pe high for one cycle, one clock after the 16th capture.
REQ-030 16 captures with i_r=i_f=1 -> o_psum=16; a following window of all zeros -> o_psum=0 with a second end_pe pulse exactly 16 cycles later.
REQ-031 16 captures with i_r=i_f=255 (width 8) -> o_psum=57360 (1040400 mod 65536).
REQ-032 Window 1..16 as in REQ-029 with en held low for 5 cycles after sample 8 -> same o_psum=14; end_pe delayed by 5 cycles; no pulse while en is low.
REQ-033 rstn asserted after sample 10, then 16 captures of i_r=i_f=2 -> o_psum and end_pe read 0 during reset, then o_psum=64.
REQ-034 Continuous en over 48 samples -> exactly 3 end_pe pulses, spaced 16 cycles apart, each with the correct window sum.
